// File: rtl/ram_port_ctrl.sv
// Single-port RAM front end: zero-fills the array after reset, then maps valid/ready
// requests onto RAM accesses with a 2-entry response buffer. Optional: RAM_PORT_CTRL_WRACK_EN.
module ram_port_ctrl #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 256,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [SIZE-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SIZE-1:0] rsp_rdata,
    output logic            rsp_write,
    output logic            init_done,
    output logic [AW-1:0]   ram_address,
    output logic [SIZE-1:0] ram_write_data,
    output logic            ram_write_en,
    input  logic [SIZE-1:0] ram_read_data
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    state_t          state;
    logic [AW-1:0]   init_cnt;

    logic            run;
    logic            addr_ok;
    logic            pop;
    logic            push;
    logic            credit_ok;
    logic            takes_credit;
    logic            accept;
    logic            issue;

    logic            inflight;
    logic            inflight_wr;
    logic            inflight_oob;
    logic [SIZE-1:0] push_data;

    logic [1:0]      count;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [SIZE-1:0] fifo_data [2];
`ifdef RAM_PORT_CTRL_WRACK_EN
    logic            fifo_wr   [2];
`endif

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign run       = (state == RUN);
    assign init_done = run;
    assign addr_ok   = ({1'b0, req_addr} < DEPTH_W);
    assign pop       = rsp_valid & rsp_ready;

    // Buffered + in-flight responses, less the one leaving this cycle, must leave a free slot.
    assign credit_ok = (({1'b0, count} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);

`ifdef RAM_PORT_CTRL_WRACK_EN
    assign takes_credit = 1'b1;
    assign req_ready    = run & credit_ok;
`else
    assign takes_credit = ~req_write;
    assign req_ready    = run & (req_write | credit_ok);
`endif

    assign accept = req_valid & req_ready;
    assign issue  = accept & takes_credit;

    // NOTE: always_comb gives every output a default first so no path can infer a latch.
    always_comb begin
        ram_address    = '0;
        ram_write_data = '0;
        ram_write_en   = 1'b0;
        if (state == INIT) begin
            ram_address  = init_cnt;
            ram_write_en = rst_n;
        end else begin
            ram_address    = req_addr;
            ram_write_data = req_wdata;
            ram_write_en   = accept & req_write & addr_ok;
        end
    end

    // ------------------------------------------------------------------
    // Zero-fill sequencer
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == LAST_ADDR) begin
                        state    <= RUN;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + AW'(1);
                    end
                end
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracking: every credit-taking access retires one edge later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight     <= 1'b0;
            inflight_wr  <= 1'b0;
            inflight_oob <= 1'b0;
        end else begin
            inflight     <= issue;
            inflight_wr  <= issue & req_write;
            inflight_oob <= issue & ~addr_ok;
        end
    end

    assign push      = inflight;
    assign push_data = (inflight_wr | inflight_oob) ? '0 : ram_read_data;

    // ------------------------------------------------------------------
    // Response buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: buffer storage is not reset; outputs are masked by rsp_valid, so stale words never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
`ifdef RAM_PORT_CTRL_WRACK_EN
            fifo_wr[wr_ptr]   <= inflight_wr;
`endif
        end
    end

    assign rsp_valid = (count != 2'd0);
    assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr] : '0;

`ifdef RAM_PORT_CTRL_WRACK_EN
    assign rsp_write = rsp_valid & fifo_wr[rd_ptr];
`else
    assign rsp_write = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count <= 2'd2);
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                                     !(push && !pop && count == 2'd2));
    a_rsp_hold    : assert property (@(posedge clk) disable iff (!rst_n)
                                     (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata)));

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed testbench for ram_port_ctrl with a behavioural sync-read RAM (old data on read-during-write).
module tb_ram_port_ctrl;

    localparam int SIZE  = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [SIZE-1:0] req_wdata = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [SIZE-1:0] rsp_rdata;
    logic            rsp_write;
    logic            init_done;
    logic [AW-1:0]   ram_address;
    logic [SIZE-1:0] ram_write_data;
    logic            ram_write_en;
    logic [SIZE-1:0] ram_read_data;

    logic            preload = 1'b1;
    logic [SIZE-1:0] mem [DEPTH];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_port_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_write      (rsp_write),
        .init_done      (init_done),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_write_en   (ram_write_en),
        .ram_read_data  (ram_read_data)
    );

    // Garbage preload makes the zero-fill observable.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 + i;
        end else if (ram_write_en) begin
            mem[ram_address] <= ram_write_data;
        end
        ram_read_data <= mem[ram_address];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [SIZE-1:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic test_reset();
        step();
        preload = 1'b0;
        settle();
        vectors++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: ready=%b valid=%b done=%b, required 0 0 0", req_ready, rsp_valid, init_done);
        end
        vectors++;
        if (ram_write_en !== 1'b0 || ram_address !== 4'd0 || rsp_rdata !== 32'd0 || rsp_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ram: we=%b addr=%0d rdata=%h wr=%b, required 0 0 0 0",
                     ram_write_en, ram_address, rsp_rdata, rsp_write);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            settle();
            vectors++;
            if (ram_write_en !== 1'b1 || ram_address !== AW'(k) || ram_write_data !== 32'd0 ||
                init_done !== 1'b0 || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL init_cycle_%0d: we=%b addr=%0d wdata=%h done=%b ready=%b, required 1 %0d 0 0 0",
                         k, ram_write_en, ram_address, ram_write_data, init_done, req_ready, k);
            end
            step();
        end
        settle();
        vectors++;
        if (init_done !== 1'b1 || ram_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL init_done_rise: done=%b we=%b, required 1 0", init_done, ram_write_en);
        end
        step();
    endtask

    task automatic test_read_zero();
        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 4'd9, '0);
        settle();
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL read9_ready: got %b required 1", req_ready);
        end
        step();
        drive(1'b0, 1'b0, '0, '0);
        settle();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read9_latency: rsp_valid=%b required 0", rsp_valid);
        end
        step();
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_write !== 1'b0) begin
            miscompares++;
            $display("FAIL read9_data: valid=%b rdata=%h wr=%b, required 1 00000000 0", rsp_valid, rsp_rdata, rsp_write);
        end
        step();
        settle();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read9_drain: rsp_valid=%b required 0", rsp_valid);
        end
        step();
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF);
        settle();
        vectors++;
        if (req_ready !== 1'b1 || ram_write_en !== 1'b1 || ram_address !== 4'd5 || ram_write_data !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL write5_port: ready=%b we=%b addr=%0d wdata=%h, required 1 1 5 deadbeef",
                     req_ready, ram_write_en, ram_address, ram_write_data);
        end
        step();
        drive(1'b1, 1'b0, 4'd5, 32'h0);
        settle();
        vectors++;
        if (ram_write_en !== 1'b0) begin
            miscompares++;
            $display("FAIL read5_we: got %b required 0", ram_write_en);
        end
`ifndef RAM_PORT_CTRL_WRACK_EN
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL write5_no_ack: rsp_valid=%b required 0", rsp_valid);
        end
`endif
        step();
        drive(1'b0, 1'b0, '0, '0);
`ifdef RAM_PORT_CTRL_WRACK_EN
        step();
`else
        settle();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL read5_latency: rsp_valid=%b required 0", rsp_valid);
        end
        step();
`endif
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_write !== 1'b0) begin
            miscompares++;
            $display("FAIL read5_data: valid=%b rdata=%h wr=%b, required 1 deadbeef 0", rsp_valid, rsp_rdata, rsp_write);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [SIZE-1:0] exp_data [3];
        exp_data[0] = 32'h11;
        exp_data[1] = 32'h22;
        exp_data[2] = 32'h33;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, AW'(i + 1), exp_data[i]);
            settle();
            step();
        end
        drive(1'b0, 1'b0, '0, '0);
        settle();
        step();
        settle();
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, AW'(i + 1), '0);
            settle();
            vectors++;
            if (req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready_%0d: got %b required 1", i, req_ready);
            end
            if (i == 2) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== exp_data[0]) begin
                    miscompares++;
                    $display("FAIL b2b_rsp_0: valid=%b rdata=%h, required 1 %h", rsp_valid, rsp_rdata, exp_data[0]);
                end
            end
            step();
        end
        drive(1'b0, 1'b0, '0, '0);
        for (int i = 1; i < 3; i++) begin
            settle();
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_data[i]) begin
                miscompares++;
                $display("FAIL b2b_rsp_%0d: valid=%b rdata=%h, required 1 %h", i, rsp_valid, rsp_rdata, exp_data[i]);
            end
            step();
        end
        settle();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: rsp_valid=%b required 0", rsp_valid);
        end
        step();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 4'd1, '0);
        settle();
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_ready_first: got %b required 1", req_ready);
        end
        step();
        drive(1'b1, 1'b0, 4'd2, '0);
        settle();
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_ready_second: got %b required 1", req_ready);
        end
        step();
        drive(1'b1, 1'b0, 4'd3, '0);
        settle();
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready_third: got %b required 0", req_ready);
        end
        step();
        settle();
        vectors++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h11) begin
            miscompares++;
            $display("FAIL bp_full: ready=%b valid=%b rdata=%h, required 0 1 00000011", req_ready, rsp_valid, rsp_rdata);
        end
        step();
        // A write probe while read credits are exhausted.
        drive(1'b1, 1'b1, 4'd7, 32'h77);
        settle();
        vectors++;
`ifdef RAM_PORT_CTRL_WRACK_EN
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_write_probe: ready=%b required 0", req_ready);
        end
`else
        if (req_ready !== 1'b1 || rsp_rdata !== 32'h11) begin
            miscompares++;
            $display("FAIL bp_write_probe: ready=%b rdata=%h, required 1 00000011", req_ready, rsp_rdata);
        end
`endif
        step();
        drive(1'b1, 1'b0, 4'd3, '0);
        rsp_ready = 1'b1;
        settle();
        vectors++;
        if (req_ready !== 1'b1 || rsp_rdata !== 32'h11) begin
            miscompares++;
            $display("FAIL bp_release: ready=%b rdata=%h, required 1 00000011", req_ready, rsp_rdata);
        end
        step();
        drive(1'b0, 1'b0, '0, '0);
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22) begin
            miscompares++;
            $display("FAIL bp_drain_2: valid=%b rdata=%h, required 1 00000022", rsp_valid, rsp_rdata);
        end
        step();
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h33) begin
            miscompares++;
            $display("FAIL bp_drain_3: valid=%b rdata=%h, required 1 00000033", rsp_valid, rsp_rdata);
        end
        step();
        settle();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_empty: rsp_valid=%b required 0", rsp_valid);
        end
        step();
    endtask

    task automatic test_read_then_write();
        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 4'd5, '0);
        settle();
        step();
        drive(1'b1, 1'b1, 4'd5, 32'h1234_5678);
        settle();
        step();
        drive(1'b1, 1'b0, 4'd5, '0);
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL rdw_old: valid=%b rdata=%h, required 1 deadbeef", rsp_valid, rsp_rdata);
        end
        step();
        drive(1'b0, 1'b0, '0, '0);
        settle();
        step();
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL rdw_new: valid=%b rdata=%h, required 1 12345678", rsp_valid, rsp_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 4'd1, '0);
        settle();
        step();
        drive(1'b1, 1'b0, 4'd2, '0);
        settle();
        step();
        drive(1'b0, 1'b0, '0, '0);
        settle();
        step();
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'h11) begin
            miscompares++;
            $display("FAIL mid_full: valid=%b ready=%b rdata=%h, required 1 0 00000011", rsp_valid, req_ready, rsp_rdata);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || req_ready !== 1'b0 || init_done !== 1'b0 ||
            ram_write_en !== 1'b0 || ram_address !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b rdata=%h ready=%b done=%b we=%b addr=%0d, required 0 0 0 0 0 0",
                     rsp_valid, rsp_rdata, req_ready, init_done, ram_write_en, ram_address);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            settle();
            vectors++;
            if (ram_write_en !== 1'b1 || ram_address !== AW'(k) || init_done !== 1'b0) begin
                miscompares++;
                $display("FAIL refill_%0d: we=%b addr=%0d done=%b, required 1 %0d 0", k, ram_write_en, ram_address, init_done, k);
            end
            step();
        end
        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 4'd2, '0);
        settle();
        vectors++;
        if (init_done !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL refill_done: done=%b ready=%b valid=%b, required 1 1 0", init_done, req_ready, rsp_valid);
        end
        step();
        drive(1'b0, 1'b0, '0, '0);
        settle();
        step();
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL refill_read2: valid=%b rdata=%h, required 1 00000000", rsp_valid, rsp_rdata);
        end
        step();
    endtask

`ifdef RAM_PORT_CTRL_WRACK_EN
    task automatic test_wrack();
        rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 4'd3, 32'hA5);
        settle();
        step();
        drive(1'b1, 1'b0, 4'd3, '0);
        settle();
        step();
        drive(1'b0, 1'b0, '0, '0);
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL wrack_ack: valid=%b wr=%b rdata=%h, required 1 1 00000000", rsp_valid, rsp_write, rsp_rdata);
        end
        step();
        settle();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'hA5) begin
            miscompares++;
            $display("FAIL wrack_read: valid=%b wr=%b rdata=%h, required 1 0 000000a5", rsp_valid, rsp_write, rsp_rdata);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_back_to_back();
        test_backpressure();
`ifdef RAM_PORT_CTRL_WRACK_EN
        test_wrack();
`else
        test_read_then_write();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
